// File: rtl/hex_tx_formatter.sv
// Purpose: formats binary words as ASCII hex lines (prefix, digits MSB first, line end) for a TX FIFO.
// Latency: word accepted at edge N, first byte offered in cycle N+1, one byte per cycle when not full.
// Backpressure: send = ~full; while full the current byte is held stable and nothing advances.
module hex_tx_formatter #(
    parameter int          DATA_W   = 16,
    parameter logic [7:0]  PREFIX   = 8'h00,
    parameter bit          EOL_CRLF = 1'b1,
    parameter bit          UPPER    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              full,
    output logic              send,
    output logic [7:0]        data_in,
    output logic              busy
);

    localparam int NIB   = DATA_W / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_DIG  = 3'd2,
        S_CR   = 3'd3,
        S_LF   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    // A byte leaves only when a line is in progress and the FIFO has room.
    logic xfer;
    assign xfer = (state_q != S_IDLE) && !full;

    // Nibble to ASCII; letter case chosen at elaboration.
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        logic [7:0] n8;
        n8 = {4'h0, n};
        if (n < 4'd10) begin
            return 8'h30 + n8;
        end
        return (UPPER ? 8'h41 : 8'h61) + n8 - 8'd10;
    endfunction

    // State, shift register and digit counter; reset aborts any partial line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: accept in IDLE, otherwise advance one step per transferred byte.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    cnt_d   = CNT_LAST;
                    state_d = (PREFIX != 8'h00) ? S_PRE : S_DIG;
                end
            end
            S_PRE: begin
                if (xfer) begin
                    state_d = S_DIG;
                end
            end
            S_DIG: begin
                if (xfer) begin
                    shreg_d = shreg_q << 4;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = EOL_CRLF ? S_CR : S_LF;
                    end
                end
            end
            S_CR: begin
                if (xfer) begin
                    state_d = S_LF;
                end
            end
            S_LF: begin
                if (xfer) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: byte decoded straight from state/shreg so it stays stable during a stall.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        send     = !full;
        data_in  = 8'h00;
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                send     = 1'b0;
            end
            S_PRE:   data_in = PREFIX;
            S_DIG:   data_in = hex_ascii(shreg_q[DATA_W-1 -: 4]);
            S_CR:    data_in = 8'h0D;
            S_LF:    data_in = 8'h0A;
            default: begin
                busy = 1'b0;
                send = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_hex_tx_formatter.sv
// Bench for hex_tx_formatter: three parameterisations driven side by side,
// bytes written to the FIFO are captured and compared with a line model.
module tb_hex_tx_formatter;

    logic clk;
    logic rst;

    // a: defaults, b: lower-case letters, c: '>' prefix with LF-only ending
    logic        iv_a, ir_a, fu_a, sd_a, by_a;
    logic [15:0] id_a;
    logic [7:0]  dt_a;
    logic        iv_b, ir_b, fu_b, sd_b, by_b;
    logic [15:0] id_b;
    logic [7:0]  dt_b;
    logic        iv_c, ir_c, fu_c, sd_c, by_c;
    logic [15:0] id_c;
    logic [7:0]  dt_c;

    logic [7:0] cap_a[$], cap_b[$], cap_c[$];
    logic [7:0] exp_a[$], exp_b[$], exp_c[$];
    logic [7:0] mline[$];

    int n_checks = 0;
    int n_fail   = 0;

    hex_tx_formatter dut_a (
        .clk(clk), .rst(rst), .in_valid(iv_a), .in_data(id_a), .in_ready(ir_a),
        .full(fu_a), .send(sd_a), .data_in(dt_a), .busy(by_a)
    );

    hex_tx_formatter #(.UPPER(1'b0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(iv_b), .in_data(id_b), .in_ready(ir_b),
        .full(fu_b), .send(sd_b), .data_in(dt_b), .busy(by_b)
    );

    hex_tx_formatter #(.PREFIX(8'h3E), .EOL_CRLF(1'b0)) dut_c (
        .clk(clk), .rst(rst), .in_valid(iv_c), .in_data(id_c), .in_ready(ir_c),
        .full(fu_c), .send(sd_c), .data_in(dt_c), .busy(by_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO side: a byte is written at every posedge where send is high.
    always @(posedge clk) begin
        if (sd_a) cap_a.push_back(dt_a);
        if (sd_b) cap_b.push_back(dt_b);
        if (sd_c) cap_c.push_back(dt_c);
    end

    // Reference: the text line a word should produce, appended to mline.
    task automatic model_line(input logic [31:0] w, input int dw, input logic [7:0] pre,
                              input bit crlf, input bit up);
        int nv;
        if (pre != 8'h00) mline.push_back(pre);
        for (int i = dw / 4 - 1; i >= 0; i--) begin
            nv = int'((w >> (4 * i)) & 32'hF);
            if (nv < 10) mline.push_back(8'(48 + nv));
            else         mline.push_back(8'((up ? 65 : 97) + nv - 10));
        end
        if (crlf) mline.push_back(8'h0D);
        mline.push_back(8'h0A);
    endtask

    // Waits (bounded) until dut_a is back in IDLE; returns whether it got there.
    task automatic wait_idle_a(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (ir_a) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic accept_a(input logic [15:0] w);
        @(negedge clk);
        iv_a = 1'b1;
        id_a = w;
        @(negedge clk);
        iv_a = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        iv_a = 1'b1; id_a = 16'hBEEF; fu_a = 1'b0;
        iv_b = 1'b0; id_b = '0; fu_b = 1'b0;
        iv_c = 1'b0; id_c = '0; fu_c = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ir_a !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", ir_a); end
        n_checks++; if (sd_a !== 1'b0)  begin n_fail++; $display("FAIL reset_send got %b want 0", sd_a); end
        n_checks++; if (dt_a !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", dt_a); end
        n_checks++; if (by_a !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got %b want 0", by_a); end
        n_checks++; if (cap_a.size() != 0) begin n_fail++; $display("FAIL reset_no_write got %0d want 0", cap_a.size()); end
        iv_a = 1'b0;
        rst  = 1'b0;
        @(negedge clk);
        n_checks++; if (by_a !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b want 0", by_a); end
    endtask

    task automatic test_basic_line;
        bit ok;
        cap_a.delete(); mline.delete();
        model_line(32'hBEEF, 16, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        iv_a = 1'b1; id_a = 16'hBEEF;
        n_checks++; if (ir_a !== 1'b1) begin n_fail++; $display("FAIL t1_ready_before got %b want 1", ir_a); end
        @(negedge clk);
        iv_a = 1'b0;
        n_checks++; if (by_a !== 1'b1) begin n_fail++; $display("FAIL t1_busy got %b want 1", by_a); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (sd_a !== 1'b1) begin n_fail++; $display("FAIL t1_send[%0d] got %b want 1", i, sd_a); end
            n_checks++; if (dt_a !== mline[i]) begin n_fail++; $display("FAIL t1_byte[%0d] got %h want %h", i, dt_a, mline[i]); end
            n_checks++; if (ir_a !== 1'b0) begin n_fail++; $display("FAIL t1_ready_busy[%0d] got %b want 0", i, ir_a); end
            @(negedge clk);
        end
        n_checks++; if (ir_a !== 1'b1 || sd_a !== 1'b0) begin n_fail++; $display("FAIL t1_end ready/send got %b/%b want 1/0", ir_a, sd_a); end
        wait_idle_a(ok);
        n_checks++; if (cap_a.size() != mline.size()) begin n_fail++; $display("FAIL t1_count got %0d want %0d", cap_a.size(), mline.size()); end
        for (int i = 0; i < cap_a.size() && i < mline.size(); i++) begin
            n_checks++; if (cap_a[i] !== mline[i]) begin n_fail++; $display("FAIL t1_fifo[%0d] got %h want %h", i, cap_a[i], mline[i]); end
        end
    endtask

    task automatic test_stall;
        bit ok;
        cap_a.delete(); mline.delete();
        model_line(32'hBEEF, 16, 8'h00, 1'b1, 1'b1);
        accept_a(16'hBEEF);
        for (int k = 0; k < 7; k++) begin
            if (k >= 2) begin
                fu_a = 1'b1;
                #1;
                n_checks++; if (sd_a !== 1'b0)  begin n_fail++; $display("FAIL t2_stall_send[%0d] got %b want 0", k, sd_a); end
                n_checks++; if (dt_a !== 8'h45) begin n_fail++; $display("FAIL t2_stall_data[%0d] got %h want 45", k, dt_a); end
            end
            @(negedge clk);
        end
        fu_a = 1'b0;
        wait_idle_a(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL t2_timeout got busy want idle"); end
        n_checks++; if (cap_a.size() != mline.size()) begin n_fail++; $display("FAIL t2_count got %0d want %0d", cap_a.size(), mline.size()); end
        for (int i = 0; i < cap_a.size() && i < mline.size(); i++) begin
            n_checks++; if (cap_a[i] !== mline[i]) begin n_fail++; $display("FAIL t2_fifo[%0d] got %h want %h", i, cap_a[i], mline[i]); end
        end
    endtask

    task automatic test_variants;
        cap_b.delete(); cap_c.delete(); exp_b.delete(); exp_c.delete();
        mline.delete(); model_line(32'h09AF, 16, 8'h00, 1'b1, 1'b0); exp_b = mline;
        mline.delete(); model_line(32'h1234, 16, 8'h3E, 1'b0, 1'b1); exp_c = mline;
        @(negedge clk);
        iv_b = 1'b1; id_b = 16'h09AF;
        iv_c = 1'b1; id_c = 16'h1234;
        @(negedge clk);
        iv_b = 1'b0; iv_c = 1'b0;
        repeat (10) @(negedge clk);
        n_checks++; if (cap_b.size() != exp_b.size()) begin n_fail++; $display("FAIL t3_count got %0d want %0d", cap_b.size(), exp_b.size()); end
        for (int i = 0; i < cap_b.size() && i < exp_b.size(); i++) begin
            n_checks++; if (cap_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL t3_fifo[%0d] got %h want %h", i, cap_b[i], exp_b[i]); end
        end
        n_checks++; if (cap_c.size() != exp_c.size()) begin n_fail++; $display("FAIL t4_count got %0d want %0d", cap_c.size(), exp_c.size()); end
        for (int i = 0; i < cap_c.size() && i < exp_c.size(); i++) begin
            n_checks++; if (cap_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL t4_fifo[%0d] got %h want %h", i, cap_c[i], exp_c[i]); end
        end
    endtask

    task automatic test_reset_mid_line;
        bit ok;
        cap_a.delete(); mline.delete();
        model_line(32'hBEEF, 16, 8'h00, 1'b1, 1'b1);
        accept_a(16'hBEEF);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (sd_a !== 1'b0) begin n_fail++; $display("FAIL t5_send got %b want 0", sd_a); end
        n_checks++; if (ir_a !== 1'b1) begin n_fail++; $display("FAIL t5_ready got %b want 1", ir_a); end
        n_checks++; if (cap_a.size() != 3) begin n_fail++; $display("FAIL t5_partial_count got %0d want 3", cap_a.size()); end
        for (int i = 0; i < cap_a.size() && i < 3; i++) begin
            n_checks++; if (cap_a[i] !== mline[i]) begin n_fail++; $display("FAIL t5_partial[%0d] got %h want %h", i, cap_a[i], mline[i]); end
        end
        @(negedge clk);
        rst = 1'b0;
        cap_a.delete(); mline.delete();
        model_line(32'h0000, 16, 8'h00, 1'b1, 1'b1);
        accept_a(16'h0000);
        wait_idle_a(ok);
        n_checks++; if (cap_a.size() != mline.size()) begin n_fail++; $display("FAIL t5_count got %0d want %0d", cap_a.size(), mline.size()); end
        for (int i = 0; i < cap_a.size() && i < mline.size(); i++) begin
            n_checks++; if (cap_a[i] !== mline[i]) begin n_fail++; $display("FAIL t5_fifo[%0d] got %h want %h", i, cap_a[i], mline[i]); end
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        cap_a.delete(); mline.delete();
        model_line(32'h00FF, 16, 8'h00, 1'b1, 1'b1);
        model_line(32'hA5A5, 16, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        iv_a = 1'b1; id_a = 16'h00FF;
        @(negedge clk);
        id_a = 16'hA5A5;
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (ir_a !== 1'b0) begin n_fail++; $display("FAIL t6_ignored[%0d] ready got %b want 0", k, ir_a); end
            @(negedge clk);
        end
        n_checks++; if (ir_a !== 1'b1 || sd_a !== 1'b0) begin n_fail++; $display("FAIL t6_gap ready/send got %b/%b want 1/0", ir_a, sd_a); end
        @(negedge clk);
        iv_a = 1'b0;
        n_checks++; if (sd_a !== 1'b1 || dt_a !== 8'h41) begin n_fail++; $display("FAIL t6_second_start got %b/%h want 1/41", sd_a, dt_a); end
        wait_idle_a(ok);
        n_checks++; if (cap_a.size() != 12) begin n_fail++; $display("FAIL t6_count got %0d want 12", cap_a.size()); end
        for (int i = 0; i < cap_a.size() && i < mline.size(); i++) begin
            n_checks++; if (cap_a[i] !== mline[i]) begin n_fail++; $display("FAIL t6_fifo[%0d] got %h want %h", i, cap_a[i], mline[i]); end
        end
    endtask

    // mode 0: random full; mode 1: full toggles every cycle. All three DUTs run at once.
    task automatic test_random(input int mode);
        cap_a.delete(); cap_b.delete(); cap_c.delete();
        exp_a.delete(); exp_b.delete(); exp_c.delete();
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (mode == 1) begin
                fu_a = cyc[0]; fu_b = ~cyc[0]; fu_c = cyc[0];
            end else begin
                fu_a = ($urandom_range(0, 2) == 0);
                fu_b = ($urandom_range(0, 1) == 0);
                fu_c = ($urandom_range(0, 3) == 0);
            end
            if (iv_a) iv_a = 1'b0;
            else if (ir_a && cyc < 700 && $urandom_range(0, 2) == 0) begin
                id_a = 16'($urandom); iv_a = 1'b1;
                mline.delete(); model_line({16'h0, id_a}, 16, 8'h00, 1'b1, 1'b1);
                foreach (mline[i]) exp_a.push_back(mline[i]);
            end
            if (iv_b) iv_b = 1'b0;
            else if (ir_b && cyc < 700 && $urandom_range(0, 1) == 0) begin
                id_b = 16'($urandom); iv_b = 1'b1;
                mline.delete(); model_line({16'h0, id_b}, 16, 8'h00, 1'b1, 1'b0);
                foreach (mline[i]) exp_b.push_back(mline[i]);
            end
            if (iv_c) iv_c = 1'b0;
            else if (ir_c && cyc < 700 && $urandom_range(0, 3) == 0) begin
                id_c = 16'($urandom); iv_c = 1'b1;
                mline.delete(); model_line({16'h0, id_c}, 16, 8'h3E, 1'b0, 1'b1);
                foreach (mline[i]) exp_c.push_back(mline[i]);
            end
        end
        fu_a = 1'b0; fu_b = 1'b0; fu_c = 1'b0;
        iv_a = 1'b0; iv_b = 1'b0; iv_c = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (cap_a.size() != exp_a.size()) begin n_fail++; $display("FAIL rnd%0d_a_count got %0d want %0d", mode, cap_a.size(), exp_a.size()); end
        for (int i = 0; i < cap_a.size() && i < exp_a.size(); i++) begin
            n_checks++; if (cap_a[i] !== exp_a[i]) begin n_fail++; $display("FAIL rnd%0d_a[%0d] got %h want %h", mode, i, cap_a[i], exp_a[i]); end
        end
        n_checks++; if (cap_b.size() != exp_b.size()) begin n_fail++; $display("FAIL rnd%0d_b_count got %0d want %0d", mode, cap_b.size(), exp_b.size()); end
        for (int i = 0; i < cap_b.size() && i < exp_b.size(); i++) begin
            n_checks++; if (cap_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL rnd%0d_b[%0d] got %h want %h", mode, i, cap_b[i], exp_b[i]); end
        end
        n_checks++; if (cap_c.size() != exp_c.size()) begin n_fail++; $display("FAIL rnd%0d_c_count got %0d want %0d", mode, cap_c.size(), exp_c.size()); end
        for (int i = 0; i < cap_c.size() && i < exp_c.size(); i++) begin
            n_checks++; if (cap_c[i] !== exp_c[i]) begin n_fail++; $display("FAIL rnd%0d_c[%0d] got %h want %h", mode, i, cap_c[i], exp_c[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_line();
        test_stall();
        test_variants();
        test_reset_mid_line();
        test_back_to_back();
        test_random(0);
        test_random(1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog got no finish want finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
